// File: rtl/ci_divider_pkg.sv
// ci_divider shared types and constants.
// Signed ops exist only with CI_DIVIDER_SIGNED_EN.
package ci_divider_pkg;
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] OP_UQUOT = 8'd0;
  localparam logic [7:0] OP_UREM  = 8'd1;
  localparam logic [7:0] OP_SQUOT = 8'd2;
  localparam logic [7:0] OP_SREM  = 8'd3;

  localparam int ITERATIONS = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;
endpackage

// File: rtl/ci_divider_if.sv
// Custom-instruction port bundle between CPU and CI units.
// CI_DIVIDER_SIGNED_EN does not change this interface.
interface ci_divider_if;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciDataA;
  logic [31:0] ciDataB;
  logic [31:0] ciResult;
  logic        ciDone;

  modport master (
    output ciStart, ciN, ciDataA, ciDataB,
    input  ciResult, ciDone
  );

  modport slave (
    input  ciStart, ciN, ciDataA, ciDataB,
    output ciResult, ciDone
  );
endinterface

// File: rtl/ci_divider_step.sv
// One restoring-division iteration, purely combinational.
// Used by ci_divider (CI_DIVIDER_SIGNED_EN independent).
module ci_divider_step (
  input  logic [31:0] r,
  input  logic [31:0] q,
  input  logic [31:0] divisor,
  output logic [31:0] rNext,
  output logic [31:0] qNext
);
  logic [32:0] shifted;
  logic [32:0] diff;

  // r[31] is always 0 here, so diff[32] is the sign
  assign shifted = {r, q[31]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rNext = shifted[31:0];
    qNext = {q[30:0], 1'b0};
    if (!diff[32]) begin
      rNext = diff[31:0];
      qNext = {q[30:0], 1'b1};
    end
  end
endmodule

// File: rtl/ci_divider.sv
// Iterative 32-bit restoring divider custom-instruction unit.
// Define CI_DIVIDER_SIGNED_EN to add signed quotient/remainder.
import ci_divider_pkg::*;

module ci_divider #(
  parameter logic [7:0] CUSTOM_ID = 8'd10
) (
  input  logic cpuClock,
  input  logic cpuReset,
  ci_divider_if.slave ci
);
  state_t      state;
  logic [4:0]  counter;
  logic [31:0] rReg;
  logic [31:0] qReg;
  logic [31:0] divisor;
  logic        remSel;
  logic        doneReg;
  logic [31:0] resultReg;

  logic [7:0]  opOff;
  logic        hit;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] rNext;
  logic [31:0] qNext;
  logic [31:0] qOut;
  logic [31:0] rOut;

  assign opOff = ci.ciN - CUSTOM_ID;

`ifdef CI_DIVIDER_SIGNED_EN
  logic negQ;
  logic negR;
  logic div0;
  logic isSigned;
  logic aNeg;
  logic bNeg;

  assign hit      = opOff <= OP_SREM;
  assign isSigned = opOff[1];
  assign aNeg     = isSigned & ci.ciDataA[31];
  assign bNeg     = isSigned & ci.ciDataB[31];
  assign aMag     = aNeg ? -ci.ciDataA : ci.ciDataA;
  assign bMag     = bNeg ? -ci.ciDataB : ci.ciDataB;
  // divide-by-zero results bypass the sign fix-up
  assign qOut = (negQ && !div0) ? -qReg : qReg;
  assign rOut = (negR && !div0) ? -rReg : rReg;
`else
  assign hit  = opOff <= OP_UREM;
  assign aMag = ci.ciDataA;
  assign bMag = ci.ciDataB;
  assign qOut = qReg;
  assign rOut = rReg;
`endif

  ci_divider_step step (
    .r       (rReg),
    .q       (qReg),
    .divisor (divisor),
    .rNext   (rNext),
    .qNext   (qNext)
  );

  always_ff @(posedge cpuClock) begin
    if (!cpuReset) begin
      state     <= IDLE;
      counter   <= '0;
      rReg      <= '0;
      qReg      <= '0;
      divisor   <= '0;
      remSel    <= 1'b0;
      doneReg   <= 1'b0;
      resultReg <= '0;
`ifdef CI_DIVIDER_SIGNED_EN
      negQ      <= 1'b0;
      negR      <= 1'b0;
      div0      <= 1'b0;
`endif
    end else begin
      doneReg   <= 1'b0;
      resultReg <= '0;
      unique case (state)
        IDLE: begin
          if (ci.ciStart && hit) begin
            remSel  <= opOff[0];
            counter <= '0;
            divisor <= bMag;
`ifdef CI_DIVIDER_SIGNED_EN
            negQ    <= aNeg ^ bNeg;
            negR    <= aNeg;
            div0    <= (ci.ciDataB == '0);
`endif
            if (ci.ciDataB == '0) begin
              qReg  <= DIV0_QUOTIENT;
              rReg  <= ci.ciDataA;
              state <= DONE;
            end else begin
              qReg  <= aMag;
              rReg  <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rReg    <= rNext;
          qReg    <= qNext;
          counter <= counter + 5'd1;
          if (counter == 5'(ITERATIONS - 1))
            state <= DONE;
        end
        DONE: begin
          doneReg   <= 1'b1;
          resultReg <= remSel ? rOut : qOut;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ci.ciDone   = doneReg;
  assign ci.ciResult = resultReg;
endmodule

// File: doc/ci_divider.md
Name: ci_divider

Overview:
- Multi-cycle custom-instruction unit that consumes the CPU custom-instruction port (ciStart/ciN/ciDataA/ciDataB) and returns ciResult/ciDone.
- Implements 32-bit iterative restoring division, one quotient bit per cycle.
- Sits on the CPU's custom-instruction bus next to other CI units. Results are OR-combined, so ciResult/ciDone must be 0 whenever this unit is not completing.

Parameters:
- CUSTOM_ID, 8'd10: base ciN value. CUSTOM_ID selects unsigned quotient; CUSTOM_ID+1 selects unsigned remainder.

Ports:
- cpuClock   input   1   core clock; all logic on rising edge.
- cpuReset   input   1   synchronous, active-low reset.
- ciStart    input   1   one-cycle start strobe from decode stage.
- ciN        input   8   custom-instruction selector.
- ciDataA    input   32  dividend.
- ciDataB    input   32  divisor.
- ciResult   output  32  result; valid only while ciDone=1, otherwise 0.
- ciDone     output  1   one-cycle completion pulse.

Behaviour:
- Reset (cpuReset=0 at a clock edge): state=IDLE, ciDone=0, ciResult=0, all datapath registers 0.
  - Reset during BUSY aborts the operation; no ciDone is produced.
- Accept condition: ciStart=1 and ciN is in this unit's range and state=IDLE.
  - Any other ciN: the unit ignores the start and outputs stay 0.
  - ciStart while BUSY or DONE: ignored, no queueing.
- On accept, latch the operands, the opcode (quotient or remainder), remainder register R=0, quotient shift register Q=ciDataA, and iteration counter=0.
- States:
  - IDLE: accept -> BUSY; divisor==0 at accept -> DONE directly.
  - BUSY: each cycle, t = {R[30:0],Q[31]} - divisor (33-bit subtract).
    - t non-negative: R = t[31:0], shift 1 into Q.
    - t negative: R = {R[30:0],Q[31]}, shift 0 into Q.
    - Counter increments; after the 32nd iteration (counter==31) -> DONE.
  - DONE: ciDone=1 for exactly one cycle, ciResult = Q or R according to the latched opcode; -> IDLE.
- Latency:
  - Start accepted at edge T; ciDone high in the cycle after edge T+33, i.e. 33 cycles after start.
  - Divide by zero: ciDone in the cycle after edge T+1, with quotient=32'hFFFFFFFF and remainder=dividend.
- Back-to-back: a new start is accepted the cycle after ciDone, since DONE returns to IDLE.
- Arithmetic: widths are unsigned 32-bit with a 33-bit compare/subtract; no overflow is possible in unsigned mode.
- ciDone and ciResult are registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CI_DIVIDER_SIGNED_EN.
- Defined:
  - ciN=CUSTOM_ID+2 gives signed quotient; ciN=CUSTOM_ID+3 gives signed remainder.
  - At accept, operands are converted to magnitudes and the sign flags are latched.
  - In DONE the quotient is negated if operand signs differ; the remainder takes the dividend's sign.
  - 32'h80000000 / -1 returns quotient 32'h80000000 and remainder 0.
  - Signed divide by zero returns quotient 32'hFFFFFFFF and remainder = dividend.
- Undefined: CUSTOM_ID+2 and CUSTOM_ID+3 are not decoded and are ignored like any foreign ciN; sign logic is absent.

Decomposition:
- Package ci_divider_pkg holds:
  - state encoding: IDLE, BUSY, DONE;
  - opcode offsets: OP_UQUOT=0, OP_UREM=1, OP_SQUOT=2, OP_SREM=3;
  - ITERATIONS=32;
  - DIV0_QUOTIENT=32'hFFFFFFFF.
- One sub-module, ci_divider_step: combinational single-iteration restoring step.
  - Inputs: R, Q, divisor. Outputs: next R, next Q.
  - The FSM, counter and I/O registers remain in ci_divider.

Test Plan:
- Unsigned quotient: ciN=10, A=100, B=7 -> ciDone exactly 33 cycles after start, ciResult=14; ciResult=0 in all other cycles.
- Unsigned remainder: ciN=11, A=32'hFFFFFFFF, B=16 -> ciResult=15.
- Divide by zero: ciN=10, A=1234, B=0 -> ciDone 1 cycle after start with 32'hFFFFFFFF. With ciN=11 -> ciResult=1234.
- Foreign ciN and busy start: ciN=9 start -> no ciDone ever. During a BUSY A=50/B=5 run, a second start with A=9/B=3 is ignored -> single ciDone with 10.
- Reset mid-operation: cpuReset=0 at cycle 15 of BUSY -> no ciDone, outputs 0. A new start after reset (A=81, B=9) -> 9.
- Signed, with CI_DIVIDER_SIGNED_EN: ciN=12, A=-7, B=2 -> 32'hFFFFFFFD (-3). ciN=13 -> 32'hFFFFFFFF (-1). ciN=12, 32'h80000000/-1 -> 32'h80000000. Without the macro, ciN=12 -> no ciDone.
